// File: rtl/sn74151_pkg.sv
// Shared definitions for the sn74151 scan controller.
//   state_t  : sequencer states
//   NUM_CH   : mux inputs scanned per frame
//   SEL_W    : width of the A/B/C select bus
//   TIMER_W  : width of the settle down-counter
package sn74151_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_CH  = 8;
    localparam int SEL_W   = 3;
    localparam int TIMER_W = 4;

endpackage

// File: rtl/scan_settle_timer.sv
// Loadable down-counter used to hold the mux select lines stable.
//   i_clk      : system clock, rising edge
//   i_rst      : asynchronous active-high reset, clears the count
//   i_load     : load i_load_val (takes priority over i_dec)
//   i_load_val : value loaded on i_load
//   i_dec      : decrement by one; holds once the count reaches zero
//   o_zero     : count is zero
module scan_settle_timer
    import sn74151_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    input  logic               i_dec,
    output logic               o_zero
);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - TIMER_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/sn74151_scan_ctrl.sv
// Scan sequencer for an sn74151 8-input mux. Walks the select lines through
// channels 0..7, holds each for SETTLE_CYCLES before sampling Y (and checking
// W against it), then offers the assembled byte downstream.
//   clk, reset     : clock and asynchronous active-high reset
//   start          : begin one 8-channel scan (only seen in IDLE)
//   abort          : cancel a scan in SETTLE/SAMPLE
//   sel, strobe_n  : mux A/B/C select and active-low enable G
//   y, w_n         : mux outputs
//   data, err      : assembled frame and complement-mismatch flag
//   valid, ready   : handshake; a transfer happens at an edge where both are 1,
//                    and data/err/valid hold stable until that edge
//   busy           : state is not IDLE
//   dbg_state      : current sequencer state
// All outputs come straight from registers.
module sn74151_scan_ctrl
    import sn74151_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter bit CHECK_W       = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic [SEL_W-1:0] sel,
    output logic             strobe_n,
    input  logic             y,
    input  logic             w_n,
    output logic [7:0]       data,
    output logic             valid,
    input  logic             ready,
    output logic             err,
    output logic             busy,
    output state_t           dbg_state
);

    // Timer counts SETTLE_CYCLES-1 down to 0, so each channel spends
    // SETTLE_CYCLES cycles in SETTLE plus one in SAMPLE.
    localparam logic [TIMER_W-1:0] LP_RELOAD = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0]   LP_LAST   = SEL_W'(NUM_CH - 1);

    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic               r_strobe_n;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_err;

    state_t             w_state_nxt;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic               w_strobe_n_nxt;
    logic [7:0]         w_data_nxt;
    logic               w_valid_nxt;
    logic               w_err_nxt;
    logic               w_tmr_load;
    logic               w_tmr_dec;
    logic               w_tmr_zero;

    scan_settle_timer u_timer (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (LP_RELOAD),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_strobe_n <= 1'b1;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_strobe_n <= w_strobe_n_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_strobe_n_nxt = r_strobe_n;
        w_data_nxt     = r_data;
        w_valid_nxt    = r_valid;
        w_err_nxt      = r_err;
        w_tmr_load     = 1'b0;
        w_tmr_dec      = 1'b0;

        case (r_state)
            IDLE: begin
                w_strobe_n_nxt = 1'b1;
                w_sel_nxt      = '0;
                if (start) begin
                    w_state_nxt    = SETTLE;
                    w_strobe_n_nxt = 1'b0;
                    w_err_nxt      = 1'b0;
                    w_tmr_load     = 1'b1;
                end
            end

            SETTLE: begin
                if (abort) begin
                    w_state_nxt    = IDLE;
                    w_strobe_n_nxt = 1'b1;
                    w_sel_nxt      = '0;
                end else if (w_tmr_zero) begin
                    w_state_nxt = SAMPLE;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end

            SAMPLE: begin
                // Abort beats the final sample, so no frame is ever offered
                // from a cancelled scan.
                if (abort) begin
                    w_state_nxt    = IDLE;
                    w_strobe_n_nxt = 1'b1;
                    w_sel_nxt      = '0;
                end else begin
                    w_data_nxt[r_sel] = y;
                    if (CHECK_W && (y == w_n)) begin
                        w_err_nxt = 1'b1;
                    end
                    if (r_sel != LP_LAST) begin
                        w_sel_nxt   = r_sel + SEL_W'(1);
                        w_tmr_load  = 1'b1;
                        w_state_nxt = SETTLE;
                    end else begin
                        w_state_nxt    = DONE;
                        w_strobe_n_nxt = 1'b1;
                        w_valid_nxt    = 1'b1;
                    end
                end
            end

            DONE: begin
                // sel stays on the last channel until the frame is taken.
                if (r_valid && ready) begin
                    w_state_nxt = IDLE;
                    w_valid_nxt = 1'b0;
                    w_sel_nxt   = '0;
                end
            end

            default: begin
                w_state_nxt    = IDLE;
                w_strobe_n_nxt = 1'b1;
                w_sel_nxt      = '0;
                w_valid_nxt    = 1'b0;
            end
        endcase
    end

    assign sel       = r_sel;
    assign strobe_n  = r_strobe_n;
    assign data      = r_data;
    assign valid     = r_valid;
    assign err       = r_err;
    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

endmodule

// File: doc/sn74151_scan_ctrl.md
Name: sn74151_scan_ctrl

Overview:
- Sequencer that drives the select (A/B/C) and strobe (G) pins of an sn74151 8-input mux.
- Samples the mux Y/W outputs once per channel and assembles the eight samples into a parallel byte.
- Presents the byte downstream with a valid/ready handshake.
- Sits between the sn74151 and the consuming logic; it both feeds and consumes the mux.

Parameters:
- SETTLE_CYCLES, 2, cycles the select lines are held stable before each sample; legal range 1..15.
- CHECK_W, 1, when 1, W is required to be the complement of Y at every sample; a violation sets err.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request one 8-channel scan; honoured only in IDLE.
- abort  input  1  cancel the scan in progress.
- sel  output  3  channel select; sel[0]=A (mux P11), sel[1]=B (P10), sel[2]=C (P9).
- strobe_n  output  1  mux enable G (mux P7), active low.
- y  input  1  mux Y output (P5).
- w_n  input  1  mux W output (P6).
- data  output  8  assembled frame; data[i] = Y sampled on channel i.
- valid  output  1  data and err are valid.
- ready  input  1  downstream accepts data.
- err  output  1  complement mismatch seen during this frame; meaningful only while valid=1.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, sel=0, strobe_n=1, data=0, valid=0, err=0, busy=0, timer=0.
  - Takes effect immediately, including mid-scan; no partial frame survives.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - strobe_n=1.
  - start=1 at edge k -> SETTLE with sel=0, strobe_n=0, timer=SETTLE_CYCLES-1, err cleared.
  - start is ignored in every other state.
- SETTLE:
  - timer decrements each cycle.
  - At timer=0 -> SAMPLE.
- SAMPLE (one cycle):
  - At the closing edge, data[sel]<=y.
  - If CHECK_W=1 and y==w_n, err<=1 (sticky for the frame).
  - If sel<7: sel<=sel+1, reload timer, -> SETTLE.
  - If sel==7: -> DONE, strobe_n<=1, valid<=1.
- Latency: start accepted at edge k gives valid=1 after edge k+8*(SETTLE_CYCLES+1); with the default, k+24.
- DONE:
  - data, err and valid are held stable until valid&ready is seen at an edge.
  - Next state is IDLE, with valid=0 after that edge.
  - sel stays at 7 in DONE and is cleared to 0 on entering IDLE.
- abort:
  - In SETTLE/SAMPLE at an edge -> IDLE, strobe_n=1, sel=0, valid never asserted, data contents undefined.
  - Ignored in IDLE and DONE; a completed frame cannot be aborted.
- Simultaneous events:
  - abort together with the final SAMPLE edge: abort wins, no valid.
  - start together with ready in DONE: start is ignored.
- Outputs are registered; no combinational path from y/w_n/ready to any output.

Decomposition:
- Shared package sn74151_pkg holds:
  - state enum {IDLE, SETTLE, SAMPLE, DONE};
  - NUM_CH=8 and SEL_W=3;
  - TIMER_W=4.
- One sub-module, scan_settle_timer: loadable down-counter with load and zero-flag.

Test Plan:
- Basic frame: mux model inputs D7..D0=0xA5, SETTLE_CYCLES=2, start pulse at edge 0, ready=1 -> sel steps 0..7, each held 3 cycles; valid high after edge 24 with data=0xA5, err=0; busy low after edge 25.
- Backpressure: same as the basic frame but ready=0 for 10 cycles after valid -> data=0xA5, err and valid held constant; single handshake on the ready edge; return to IDLE.
- Complement check: w_n forced equal to y on channel 3 only -> data correct, err=1 with valid; with CHECK_W=0, err=0.
- Abort: abort pulsed while sel=3 -> next cycle state IDLE, strobe_n=1, sel=0, valid stays 0; a subsequent start yields a correct frame.
- Async reset mid-scan: reset asserted between edges while sel=5 -> outputs reach their reset values before the next edge; no valid after release.
- Start while busy / SETTLE_CYCLES=1: start pulses during the scan are ignored (exactly one frame); with SETTLE_CYCLES=1, valid after edge 16.
